cmp_arbiter: RTL

- Shares one pipelined subtract-and-compare unit among NREQ requesters, such as the execute stage and the branch resolver.
- Round-robin arbitration; one request accepted per cycle.
- Computes the Z/V/N flags of a-b, then produces the Beta CMPEQ/CMPLT/CMPLE 32-bit result.
- Sits beside the main ALU and returns results on a single valid/ready response channel, tagged with the requester id.

---
 rtl/cmp_arb_pkg.sv | 30 +++
 rtl/cmp_arbiter_rr_arb.sv | 34 +++
 rtl/cmp_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared types and the flag-to-result mapping for the compare arbiter.
// Encodes the Beta CMPEQ/CMPLT/CMPLE selection from the Z/V/N flags of a-b.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    CMPEQ    = 2'b00,
    CMPLT    = 2'b01,
    CMPLE    = 2'b10,
    CMP_RSVD = 2'b11
  } cmp_op_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } cmp_flags_t;

  // Signed less-than is v^n; equality is excluded from LT and included in LE.
  function automatic logic [31:0] cmp_result(input cmp_op_e op, input cmp_flags_t f);
    logic lt;
    lt = f.v ^ f.n;
    case (op)
      CMPEQ:   return {31'd0, f.z};
      CMPLT:   return {31'd0, lt & ~f.z};
      CMPLE:   return {31'd0, lt | f.z};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_arbiter_rr_arb.sv
// Round-robin grant: the first requesting index after ptr, wrapping modulo N.
// grant is gated by en; grant_idx always reports the winning candidate.
module rr_arb #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = ptr;
    for (int k = 0; k < N; k++) begin
      idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (en && found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin shared two-stage compare unit with a tagged valid/ready response.
// Defining CMP_ARB_STATS_EN adds per-requester saturating grant counters.
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_y,
  output logic [IDW-1:0]    rsp_id
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  logic [W-1:0] a_arr  [NREQ];
  logic [W-1:0] b_arr  [NREQ];
  logic [1:0]   op_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*W +: W];
      assign b_arr[gi]  = req_b[gi*W +: W];
      assign op_arr[gi] = req_op[gi*2 +: 2];
    end
  endgenerate

  logic           s1_v_reg;
  logic [W-1:0]   s1_a_reg;
  logic [W-1:0]   s1_b_reg;
  cmp_op_e        s1_op_reg;
  logic [IDW-1:0] s1_id_reg;
  logic           s2_v_reg;
  logic [31:0]    s2_y_reg;
  logic [IDW-1:0] s2_id_reg;
  logic [IDW-1:0] rr_ptr_reg;

  logic           s2_adv;
  logic           s1_adv;
  logic           accept;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           handshake;

  assign s2_adv = !s2_v_reg | rsp_ready;
  assign s1_adv = !s1_v_reg | s2_adv;
  // Holding accept low in reset keeps req_ready quiet while the pipe flushes.
  assign accept = s1_adv & !reset;

  rr_arb #(
    .N  (NREQ),
    .PW (IDW)
  ) u_rr_arb (
    .req       (req_valid),
    .en        (accept),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign handshake = |grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= IDW'(NREQ - 1);
      s1_v_reg   <= 1'b0;
    end else if (s1_adv) begin
      s1_v_reg <= handshake;
      if (handshake) begin
        rr_ptr_reg <= grant_idx;
        s1_a_reg   <= a_arr[grant_idx];
        s1_b_reg   <= b_arr[grant_idx];
        s1_op_reg  <= cmp_op_e'(op_arr[grant_idx]);
        s1_id_reg  <= grant_idx;
      end
    end
  end

  logic [W-1:0] diff;
  cmp_flags_t   flags;

  assign diff    = s1_a_reg - s1_b_reg;
  assign flags.z = (diff == '0);
  assign flags.n = diff[W-1];
  assign flags.v = (s1_a_reg[W-1] & ~s1_b_reg[W-1] & ~diff[W-1]) |
                   (~s1_a_reg[W-1] & s1_b_reg[W-1] & diff[W-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v_reg  <= 1'b0;
      s2_y_reg  <= '0;
      s2_id_reg <= '0;
    end else if (s2_adv) begin
      s2_v_reg <= s1_v_reg;
      if (s1_v_reg) begin
        s2_y_reg  <= cmp_result(s1_op_reg, flags);
        s2_id_reg <= s1_id_reg;
      end
    end
  end

  assign rsp_valid = s2_v_reg;
  assign rsp_y     = s2_y_reg;
  assign rsp_id    = s2_id_reg;

`ifdef CMP_ARB_STATS_EN
  logic [15:0] cnt_reg [NREQ];

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stats
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (grant[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
      end
      assign grant_cnt[gi*16 +: 16] = cnt_reg[gi];
    end
  endgenerate
`endif

endmodule
